// File: rtl/noc_proc_if_pkg.sv
// Shared definitions for the processor-side NoC interface: TX/RX state
// encodings, header flit field offsets and the header-build helper.
package noc_proc_if_pkg;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_LOAD = 2'd1,
        T_REQ  = 2'd2,
        T_REL  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_HOLD = 2'd1,
        R_ACK  = 2'd2
    } rx_state_e;

    // Header flit layout; bits above HDR_W are always zero.
    localparam int HDR_DSTX_LSB = 0;
    localparam int HDR_DSTY_LSB = 4;
    localparam int HDR_LEN_LSB  = 8;
    localparam int HDR_SRCX_LSB = 16;
    localparam int HDR_SRCY_LSB = 20;
    localparam int HDR_W        = 24;

    function automatic logic [HDR_W-1:0] build_hdr(
        input logic [3:0] dstx,
        input logic [3:0] dsty,
        input logic [7:0] len,
        input logic [3:0] srcx,
        input logic [3:0] srcy
    );
        logic [HDR_W-1:0] h;
        h = '0;
        h[HDR_DSTX_LSB +: 4] = dstx;
        h[HDR_DSTY_LSB +: 4] = dsty;
        h[HDR_LEN_LSB  +: 8] = len;
        h[HDR_SRCX_LSB +: 4] = srcx;
        h[HDR_SRCY_LSB +: 4] = srcy;
        return h;
    endfunction

endpackage

// File: rtl/noc_sync2.sv
// Single-bit two-flop synchronizer with asynchronous active-low reset.
module noc_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/noc_proc_if.sv
// Processor-side network interface: packetises TX requests into header +
// payload flits over a four-phase req/ack link to the router, and unpacks
// incoming flits into a valid/ready stream flagged with rx_hdr.
// Optional build macro: NOC_IF_SYNC_EN inserts two-flop synchronizers on
// net_ack_i and rx_req_i (router in another clock domain).
module noc_proc_if import noc_proc_if_pkg::*; #(
    parameter int n    = 32,
    parameter int srcx = 0,
    parameter int srcy = 0,
    parameter int maxx = 2,
    parameter int maxy = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tx_start,
    input  logic [3:0]   tx_dstx,
    input  logic [3:0]   tx_dsty,
    input  logic [7:0]   tx_len,
    output logic         tx_busy,
    output logic         tx_err,
    input  logic [n-1:0] tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic [n-1:0] net_data_o,
    output logic         net_req_o,
    input  logic         net_ack_i,
    input  logic [n-1:0] rx_data_i,
    input  logic         rx_req_i,
    output logic         rx_ack_o,
    output logic [n-1:0] rx_data,
    output logic         rx_valid,
    output logic         rx_hdr,
    input  logic         rx_ready
);

    localparam logic [3:0] MAXX4 = 4'(maxx);
    localparam logic [3:0] MAXY4 = 4'(maxy);
    localparam logic [3:0] SRCX4 = 4'(srcx);
    localparam logic [3:0] SRCY4 = 4'(srcy);

    logic ack_s;
    logic req_s;

`ifdef NOC_IF_SYNC_EN
    noc_sync2 u_sync_ack (.clk_i(clk), .rst_ni(rst), .d_i(net_ack_i), .q_o(ack_s));
    noc_sync2 u_sync_req (.clk_i(clk), .rst_ni(rst), .d_i(rx_req_i),  .q_o(req_s));
`else
    assign ack_s = net_ack_i;
    assign req_s = rx_req_i;
`endif

    tx_state_e    tx_state_q, tx_state_d;
    logic [7:0]   tx_cnt_q, tx_cnt_d;
    logic [n-1:0] net_data_q, net_data_d;
    logic         net_req_q, net_req_d;
    logic         tx_err_q, tx_err_d;
    logic         tx_ready_c;
    logic [n-1:0] hdr_flit;
    logic         dst_legal;

    rx_state_e    rx_state_q, rx_state_d;
    logic [7:0]   rx_cnt_q, rx_cnt_d;
    logic [n-1:0] rx_data_q, rx_data_d;
    logic         rx_valid_q, rx_valid_d;
    logic         rx_hdr_q, rx_hdr_d;
    logic         rx_ack_q, rx_ack_d;

    // Header word for the pending start request, zero-extended to flit width.
    always_comb begin
        hdr_flit = '0;
        hdr_flit[HDR_W-1:0] = build_hdr(tx_dstx, tx_dsty, tx_len, SRCX4, SRCY4);
    end

    assign dst_legal = (tx_dstx <= MAXX4) && (tx_dsty <= MAXY4);

    // TX next-state: data is loaded in T_LOAD a cycle before req rises and
    // only changes again once the router has released ack.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        net_data_d = net_data_q;
        net_req_d  = net_req_q;
        tx_err_d   = 1'b0;
        tx_ready_c = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                if (tx_start) begin
                    if (dst_legal) begin
                        tx_state_d = T_LOAD;
                        net_data_d = hdr_flit;
                        tx_cnt_d   = tx_len;
                    end else begin
                        tx_err_d = 1'b1;
                    end
                end
            end
            T_LOAD: begin
                tx_state_d = T_REQ;
                net_req_d  = 1'b1;
            end
            T_REQ: begin
                if (ack_s) begin
                    tx_state_d = T_REL;
                    net_req_d  = 1'b0;
                end
            end
            T_REL: begin
                if (!ack_s) begin
                    if (tx_cnt_q == 8'd0) begin
                        tx_state_d = T_IDLE;
                    end else if (tx_valid) begin
                        tx_ready_c = 1'b1;
                        net_data_d = tx_data;
                        tx_cnt_d   = tx_cnt_q - 8'd1;
                        tx_state_d = T_LOAD;
                    end
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    // TX state register; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= T_IDLE;
            tx_cnt_q   <= 8'd0;
            net_data_q <= '0;
            net_req_q  <= 1'b0;
            tx_err_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            net_data_q <= net_data_d;
            net_req_q  <= net_req_d;
            tx_err_q   <= tx_err_d;
        end
    end

    // RX next-state: a zero payload counter means the next flit is a header.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_hdr_d   = rx_hdr_q;
        rx_ack_d   = rx_ack_q;
        case (rx_state_q)
            R_IDLE: begin
                if (req_s) begin
                    rx_data_d  = rx_data_i;
                    rx_valid_d = 1'b1;
                    rx_hdr_d   = (rx_cnt_q == 8'd0);
                    if (rx_cnt_q == 8'd0) begin
                        rx_cnt_d = rx_data_i[HDR_LEN_LSB +: 8];
                    end else begin
                        rx_cnt_d = rx_cnt_q - 8'd1;
                    end
                    rx_state_d = R_HOLD;
                end
            end
            R_HOLD: begin
                if (rx_ready) begin
                    rx_valid_d = 1'b0;
                    rx_hdr_d   = 1'b0;
                    rx_ack_d   = 1'b1;
                    rx_state_d = R_ACK;
                end
            end
            R_ACK: begin
                if (!req_s) begin
                    rx_ack_d   = 1'b0;
                    rx_state_d = R_IDLE;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    // RX state register; reset forces the next received flit to be a header.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= R_IDLE;
            rx_cnt_q   <= 8'd0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_hdr_q   <= 1'b0;
            rx_ack_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_hdr_q   <= rx_hdr_d;
            rx_ack_q   <= rx_ack_d;
        end
    end

    assign tx_busy    = (tx_state_q != T_IDLE);
    assign tx_err     = tx_err_q;
    assign tx_ready   = tx_ready_c;
    assign net_data_o = net_data_q;
    assign net_req_o  = net_req_q;
    assign rx_ack_o   = rx_ack_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_hdr     = rx_hdr_q;

endmodule
